// File: rtl/matching_engine_if.sv
// Price-feed side and best-price/trade side of the matcher, grouped as one bus.
// The DUT takes the slave modport; the feed and the reporting logic take the master modport.
interface matching_engine_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] buy_price;
   logic [WIDTH-1:0] sell_price;
   logic [WIDTH-1:0] best_bid;
   logic [WIDTH-1:0] best_ask;
   logic             match_flag;
   logic [WIDTH-1:0] trade_price;

   modport master (
      output buy_price, sell_price,
      input  best_bid, best_ask, match_flag, trade_price
   );

   modport slave (
      input  buy_price, sell_price,
      output best_bid, best_ask, match_flag, trade_price
   );
endinterface

// File: rtl/matching_engine.sv
// Sliding-window matcher: max bid / min ask over the last WINDOW samples, cross flag, mid trade price.
// Latency 1 cycle; no backpressure, a buy and a sell sample are consumed on every clock.
module matching_engine #(
   parameter int WIDTH  = 8,
   parameter int WINDOW = 8
) (
   input  logic              clk,
   input  logic              reset,
   matching_engine_if.slave  bus
);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   // Only WINDOW-1 samples are stored; the incoming sample completes the window.
   logic [WIDTH-1:0] buy_win_q  [WINDOW-1];
   logic [WIDTH-1:0] buy_win_d  [WINDOW-1];
   logic [WIDTH-1:0] sell_win_q [WINDOW-1];
   logic [WIDTH-1:0] sell_win_d [WINDOW-1];

   logic [WIDTH-1:0] best_bid_q, best_bid_d;
   logic [WIDTH-1:0] best_ask_q, best_ask_d;
   logic             match_q, match_d;
   logic [WIDTH-1:0] trade_q, trade_d;

   always_comb begin
      buy_win_d[0]  = bus.buy_price;
      sell_win_d[0] = bus.sell_price;
      for (int i = 1; i < WINDOW - 1; i++) begin
         buy_win_d[i]  = buy_win_q[i-1];
         sell_win_d[i] = sell_win_q[i-1];
      end

      best_bid_d = bus.buy_price;
      best_ask_d = bus.sell_price;
      for (int i = 0; i < WINDOW - 1; i++) begin
         if (buy_win_q[i] > best_bid_d)
            best_bid_d = buy_win_q[i];
         if (sell_win_q[i] < best_ask_d)
            best_ask_d = sell_win_q[i];
      end

      match_d = (best_bid_d >= best_ask_d);
      // One extra sum bit so 255+255 does not wrap before halving.
      trade_d = match_d ? WIDTH'(({1'b0, best_bid_d} + {1'b0, best_ask_d}) >> 1) : trade_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WINDOW - 1; i++) begin
            buy_win_q[i]  <= '0;
            sell_win_q[i] <= ALL_ONES;
         end
         best_bid_q <= '0;
         best_ask_q <= ALL_ONES;
         match_q    <= 1'b0;
         trade_q    <= '0;
      end else begin
         buy_win_q  <= buy_win_d;
         sell_win_q <= sell_win_d;
         best_bid_q <= best_bid_d;
         best_ask_q <= best_ask_d;
         match_q    <= match_d;
         trade_q    <= trade_d;
      end
   end

   assign bus.best_bid    = best_bid_q;
   assign bus.best_ask    = best_ask_q;
   assign bus.match_flag  = match_q;
   assign bus.trade_price = trade_q;
endmodule

// File: tb/tb_matching_engine.sv
// Scoreboard bench: the driver pushes reference-model expectations, a monitor pops and compares each cycle.
module tb_matching_engine;
   localparam int WIDTH  = 8;
   localparam int WINDOW = 8;

   logic clk;
   logic reset;

   matching_engine_if #(.WIDTH(WIDTH)) bus ();

   matching_engine #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int    bid;
      int    ask;
      int    m;
      int    tr;
      bit    dir;
      int    dbid;
      int    dask;
      int    dm;
      int    dtr;
      string name;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: full sample history since reset, extrema over the last WINDOW entries.
   int buy_h[$];
   int sell_h[$];
   int trade_m = 0;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic step(input bit r, input int b, input int s, input string nm = "rnd",
                       input bit dir = 1'b0, input int db = 0, input int da = 0,
                       input int dm = 0, input int dt = 0);
      exp_t e;
      int   bid;
      int   ask;
      @(negedge clk);
      reset          = r;
      bus.buy_price  = b[WIDTH-1:0];
      bus.sell_price = s[WIDTH-1:0];
      if (r) begin
         buy_h.delete();
         sell_h.delete();
         trade_m = 0;
         bid = 0;
         ask = 255;
      end else begin
         buy_h.push_back(b);
         sell_h.push_back(s);
         if (buy_h.size() > WINDOW) void'(buy_h.pop_front());
         if (sell_h.size() > WINDOW) void'(sell_h.pop_front());
         bid = 0;
         ask = 255;
         foreach (buy_h[i])  if (buy_h[i] > bid)  bid = buy_h[i];
         foreach (sell_h[i]) if (sell_h[i] < ask) ask = sell_h[i];
         if (bid >= ask) trade_m = (bid + ask) / 2;
      end
      e.bid  = bid;
      e.ask  = ask;
      e.m    = (!r && bid >= ask) ? 1 : 0;
      e.tr   = trade_m;
      e.dir  = dir;
      e.dbid = db;
      e.dask = da;
      e.dm   = dm;
      e.dtr  = dt;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".bid"},   int'(bus.best_bid),    e.bid);
            chk({e.name, ".ask"},   int'(bus.best_ask),    e.ask);
            chk({e.name, ".match"}, int'(bus.match_flag),  e.m);
            chk({e.name, ".trade"}, int'(bus.trade_price), e.tr);
            if (e.dir) begin
               chk({e.name, ".spec_bid"},   int'(bus.best_bid),    e.dbid);
               chk({e.name, ".spec_ask"},   int'(bus.best_ask),    e.dask);
               chk({e.name, ".spec_match"}, int'(bus.match_flag),  e.dm);
               chk({e.name, ".spec_trade"}, int'(bus.trade_price), e.dtr);
            end
         end
      end
   end

   initial begin
      int b;
      int s;
      bit r;
      reset          = 1'b1;
      bus.buy_price  = '0;
      bus.sell_price = '0;

      for (int i = 0; i < 5; i++) step(1'b1, 0, 0, "reset", 1'b1, 0, 255, 0, 0);

      for (int i = 0; i < 8; i++)
         step(1'b0, 60 + 2*i, 90 - 2*i, "fill", 1'b1, 60 + 2*i, 90 - 2*i, 0, 0);

      step(1'b0, 80, 78, "cross1", 1'b1, 80, 76, 1, 78);
      step(1'b0, 82, 75, "cross2", 1'b1, 82, 75, 1, 78);

      for (int i = 0; i < 4; i++) step(1'b0, 85, 60, "ext_in", 1'b1, 85, 60, 1, 72);
      for (int k = 0; k < 7; k++) step(1'b0, 55, 85, "ext_hold", 1'b1, 85, 60, 1, 72);
      step(1'b0, 55, 85, "ext_aged", 1'b1, 55, 85, 0, 72);

      for (int i = 0; i < 8; i++) step(1'b0, 255, 255, "all_ones");
      step(1'b0, 255, 255, "ovf", 1'b1, 255, 255, 1, 255);

      step(1'b1, 0, 0, "zero_rst", 1'b1, 0, 255, 0, 0);
      for (int i = 0; i < 9; i++) step(1'b0, 0, 0, "zeros");

      step(1'b1, 0, 0, "pre_rst");
      for (int i = 0; i < 5; i++) step(1'b0, 60 + 2*i, 90 - 2*i, "refill");
      step(1'b0, 80, 78, "mid_cross");
      step(1'b1, 80, 78, "mid_rst", 1'b1, 0, 255, 0, 0);
      step(1'b0, 80, 78, "post_rst", 1'b1, 80, 78, 1, 79);
      step(1'b0, 70, 90, "post_rst2", 1'b1, 80, 78, 1, 79);

      for (int n = 0; n < 400; n++) begin
         r = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 3))
            0: begin b = $urandom_range(0, 255);   s = $urandom_range(0, 255);   end
            1: begin b = $urandom_range(100, 200); s = $urandom_range(80, 180);  end
            2: begin b = $urandom_range(0, 1) * 255; s = $urandom_range(0, 1) * 255; end
            default: begin b = $urandom_range(40, 120); s = $urandom_range(110, 200); end
         endcase
         step(r, b, s);
      end

      @(negedge clk);
      reset = 1'b0;
      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
